re_name_commit: RTL and testbench

- Commit-side counterpart of the issue-stage register renamer.
- The renamer hands out physical names {toggle bit, arch index}, where the toggle bit is flipped per architectural destination on each issue. This block receives committed instructions carrying those physical destinations.
- It converts them back to architectural write addresses, frees the superseded physical register, and maintains the committed rename table.
- On a pipeline flush it delivers the committed table so the speculative table can be restored.

---
 rtl/re_name_commit.sv | 105 ++++++++++
 tb/tb_re_name_commit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/re_name_commit.sv
// Commit-side renamer: maps physical destinations back to architectural writes and frees superseded registers.
// Latency: commit handshakes are combinational; the committed table updates one edge later; restore_valid_o follows flush_i by one cycle.
// Backpressure: commits stall while a flush is requested or a restore is pending; a restore is held until restore_ready_i.
package re_name_commit_pkg;
    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  op;
        logic [5:0]  rd;
    } scoreboard_entry_t;
endpackage

module re_name_commit
    import re_name_commit_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int NR_ARCH_REGS    = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
    input  logic [NR_COMMIT_PORTS-1:0]             commit_valid_i,
    output logic [NR_COMMIT_PORTS-1:0]             commit_ack_o,
    output logic [NR_COMMIT_PORTS-1:0][4:0]        arch_waddr_o,
    output logic [NR_COMMIT_PORTS-1:0]             arch_we_o,
    output logic [NR_COMMIT_PORTS-1:0]             free_valid_o,
    output logic [NR_COMMIT_PORTS-1:0][5:0]        free_preg_o,
    input  logic                                   flush_i,
    output logic                                   restore_valid_o,
    input  logic                                   restore_ready_i,
    output logic [NR_ARCH_REGS-1:0]                restore_table_o,
    output logic                                   mismatch_o
);

    typedef enum logic {IDLE, RESTORE} state_e;

    state_e                    state_q, state_d;
    logic [NR_ARCH_REGS-1:0]   table_q, table_d;
    logic                      mismatch_q, mismatch_d;
    logic [NR_COMMIT_PORTS-1:0] ack;
    logic                      unused_fields;

    always_comb begin
        unused_fields = 1'b0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            unused_fields = unused_fields ^ (^commit_instr_i[i].pc) ^ (^commit_instr_i[i].op);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (flush_i) state_d = RESTORE;
            RESTORE: if (restore_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ports are walked oldest first so each port's check sees the table as left by older ports.
    always_comb begin
        ack          = '0;
        arch_waddr_o = '0;
        arch_we_o    = '0;
        free_valid_o = '0;
        free_preg_o  = '0;
        table_d      = table_q;
        mismatch_d   = mismatch_q;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (i == 0) begin
                ack[i] = commit_valid_i[i] & (state_q == IDLE) & ~flush_i;
            end else begin
                ack[i] = commit_valid_i[i] & ack[i-1];
            end
            if (ack[i]) begin
                arch_waddr_o[i] = commit_instr_i[i].rd[4:0];
                arch_we_o[i]    = (commit_instr_i[i].rd[4:0] != 5'd0);
                free_valid_o[i] = arch_we_o[i];
                free_preg_o[i]  = {~commit_instr_i[i].rd[5], commit_instr_i[i].rd[4:0]};
                if (arch_we_o[i] &&
                    (commit_instr_i[i].rd[5] != ~table_d[commit_instr_i[i].rd[4:0]])) begin
                    mismatch_d = 1'b1;
                end
                table_d[commit_instr_i[i].rd[4:0]] = ~table_d[commit_instr_i[i].rd[4:0]];
            end
        end
        table_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            table_q    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            table_q    <= table_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign commit_ack_o    = ack;
    assign restore_valid_o = (state_q == RESTORE);
    assign restore_table_o = table_q;
    assign mismatch_o      = mismatch_q;

endmodule

// File: tb/tb_re_name_commit.sv
// Directed bench for re_name_commit: commit mapping, committed-table restore, and sticky mismatch.
module tb_re_name_commit;
    import re_name_commit_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    scoreboard_entry_t [1:0] commit_instr_i;
    logic [1:0]              commit_valid_i;
    logic [1:0]              commit_ack_o;
    logic [1:0][4:0]         arch_waddr_o;
    logic [1:0]              arch_we_o;
    logic [1:0]              free_valid_o;
    logic [1:0][5:0]         free_preg_o;
    logic                    flush_i;
    logic                    restore_valid_o;
    logic                    restore_ready_i;
    logic [31:0]             restore_table_o;
    logic                    mismatch_o;

    int checks = 0;
    int errors = 0;

    re_name_commit #(.NR_COMMIT_PORTS(2), .NR_ARCH_REGS(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .commit_instr_i  (commit_instr_i),
        .commit_valid_i  (commit_valid_i),
        .commit_ack_o    (commit_ack_o),
        .arch_waddr_o    (arch_waddr_o),
        .arch_we_o       (arch_we_o),
        .free_valid_o    (free_valid_o),
        .free_preg_o     (free_preg_o),
        .flush_i         (flush_i),
        .restore_valid_o (restore_valid_o),
        .restore_ready_i (restore_ready_i),
        .restore_table_o (restore_table_o),
        .mismatch_o      (mismatch_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; combinational checks follow 1ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] vld, input logic [5:0] rd0, input logic [5:0] rd1);
        commit_valid_i       = vld;
        commit_instr_i[0].rd = rd0;
        commit_instr_i[1].rd = rd1;
        #1;
    endtask

    task automatic do_restore(input string tag, input logic [31:0] exp_tbl);
        drive(2'b00, 6'd0, 6'd0);
        flush_i         = 1'b1;
        restore_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        check({tag, "_rvalid"}, 32'(restore_valid_o), 32'd1);
        check({tag, "_table"}, restore_table_o, exp_tbl);
        tick();
        check({tag, "_idle"}, 32'(restore_valid_o), 32'd0);
    endtask

    initial begin
        rst_ni          = 1'b0;
        commit_instr_i  = '0;
        commit_valid_i  = 2'b00;
        flush_i         = 1'b0;
        restore_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1;
        check("rst_ack", 32'(commit_ack_o), 32'd0);
        check("rst_we", 32'(arch_we_o), 32'd0);
        check("rst_free", 32'(free_valid_o), 32'd0);
        check("rst_rvalid", 32'(restore_valid_o), 32'd0);
        check("rst_mismatch", 32'(mismatch_o), 32'd0);
        check("rst_table", restore_table_o, 32'h0);
        do_restore("rst_restore", 32'h0);

        // Single commit on port 0, toggle 1 for x5.
        drive(2'b01, 6'b100101, 6'd0);
        check("s1_ack", 32'(commit_ack_o), 32'h1);
        check("s1_waddr", 32'(arch_waddr_o[0]), 32'd5);
        check("s1_we", 32'(arch_we_o), 32'h1);
        check("s1_free_vld", 32'(free_valid_o), 32'h1);
        check("s1_free_preg", 32'(free_preg_o[0]), 32'd5);
        tick();
        do_restore("s1_restore", 32'h0000_0020);

        drive(2'b01, 6'd5, 6'd0);
        check("s2_ack", 32'(commit_ack_o), 32'h1);
        check("s2_free_preg", 32'(free_preg_o[0]), 32'd37);
        tick();
        check("s2_mismatch", 32'(mismatch_o), 32'd0);
        do_restore("s2_restore", 32'h0);

        // Both ports retire x5 in one cycle: double toggle.
        drive(2'b11, 6'd37, 6'd5);
        check("d_ack", 32'(commit_ack_o), 32'h3);
        check("d_we", 32'(arch_we_o), 32'h3);
        check("d_free0", 32'(free_preg_o[0]), 32'd5);
        check("d_free1", 32'(free_preg_o[1]), 32'd37);
        tick();
        check("d_mismatch", 32'(mismatch_o), 32'd0);
        do_restore("d_restore", 32'h0);

        drive(2'b10, 6'd0, 6'd41);
        check("inorder_ack", 32'(commit_ack_o), 32'h0);
        check("inorder_we", 32'(arch_we_o), 32'h0);
        check("inorder_free", 32'(free_valid_o), 32'h0);
        check("inorder_waddr1", 32'(arch_waddr_o[1]), 32'd0);
        tick();

        // Register zero never writes or frees.
        drive(2'b11, 6'd0, 6'd32);
        check("x0_ack", 32'(commit_ack_o), 32'h3);
        check("x0_we", 32'(arch_we_o), 32'h0);
        check("x0_free", 32'(free_valid_o), 32'h0);
        check("x0_preg0", 32'(free_preg_o[0]), 32'd32);
        check("x0_preg1", 32'(free_preg_o[1]), 32'd0);
        tick();
        check("x0_mismatch", 32'(mismatch_o), 32'd0);

        // x3 and x7 committed, then a held restore.
        drive(2'b11, 6'd35, 6'd39);
        check("f_pre_ack", 32'(commit_ack_o), 32'h3);
        tick();
        flush_i         = 1'b1;
        restore_ready_i = 1'b0;
        drive(2'b11, 6'd35, 6'd39);
        check("f_flush_ack", 32'(commit_ack_o), 32'h0);
        tick();
        flush_i = 1'b0;
        #1;
        check("f_rvalid", 32'(restore_valid_o), 32'd1);
        check("f_table", restore_table_o, 32'h0000_0088);
        for (int c = 0; c < 3; c++) begin
            flush_i = (c == 1);
            #1;
            check($sformatf("f_hold%0d_rvalid", c), 32'(restore_valid_o), 32'd1);
            check($sformatf("f_hold%0d_table", c), restore_table_o, 32'h0000_0088);
            check($sformatf("f_hold%0d_ack", c), 32'(commit_ack_o), 32'h0);
            tick();
        end
        flush_i         = 1'b0;
        restore_ready_i = 1'b1;
        #1;
        check("f_release_rvalid", 32'(restore_valid_o), 32'd1);
        tick();
        check("f_back_idle", 32'(restore_valid_o), 32'd0);
        drive(2'b01, 6'd3, 6'd0);
        check("f_resume_ack", 32'(commit_ack_o), 32'h1);
        tick();
        check("f_resume_mismatch", 32'(mismatch_o), 32'd0);

        // Wrong toggle on x9 sets the sticky flag.
        drive(2'b01, 6'd9, 6'd0);
        check("m_ack", 32'(commit_ack_o), 32'h1);
        tick();
        check("m_set", 32'(mismatch_o), 32'd1);
        drive(2'b01, 6'd9, 6'd0);
        tick();
        check("m_sticky", 32'(mismatch_o), 32'd1);
        do_restore("m_restore", 32'h0000_0080);
        check("m_after_flush", 32'(mismatch_o), 32'd1);

        // Reset in the middle of a restore.
        drive(2'b00, 6'd0, 6'd0);
        flush_i         = 1'b1;
        restore_ready_i = 1'b0;
        tick();
        flush_i = 1'b0;
        check("r_rvalid_pre", 32'(restore_valid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("r_abort", 32'(restore_valid_o), 32'd0);
        check("r_mismatch", 32'(mismatch_o), 32'd0);
        check("r_table", restore_table_o, 32'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("r_still_idle", 32'(restore_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
